// File: rtl/router_pkg.sv
// Shared definitions for the router input unit: output port indices, flit
// preamble and header layout, the one-hot route type, the input-unit FSM
// states and the dimension-ordered route selection.
// Build option: ROUTER_INPUT_UNIT_YX_ROUTING_EN selects YX order (default XY).
package router_pkg;

  localparam int NORTH     = 0;
  localparam int SOUTH     = 1;
  localparam int WEST      = 2;
  localparam int EAST      = 3;
  localparam int LOCAL     = 4;
  localparam int NUM_PORTS = 5;

  // Header field offsets, counted down from the flit MSB.
  localparam int HEAD_OFS   = 0;
  localparam int TAIL_OFS   = 1;
  localparam int DEST_Y_OFS = 2;

  typedef logic [NUM_PORTS-1:0] route_t;

  typedef enum logic {
    IU_IDLE,
    IU_PACKET
  } iu_state_t;

  // Dimension-ordered routing from pre-computed unsigned coordinate
  // comparisons (destination vs. this router), so it is independent of the
  // coordinate width.
  function automatic route_t route_select(input logic x_gt, input logic x_lt,
                                          input logic y_gt, input logic y_lt);
    route_t r;
    r = '0;
`ifdef ROUTER_INPUT_UNIT_YX_ROUTING_EN
    if (y_lt)      r[NORTH] = 1'b1;
    else if (y_gt) r[SOUTH] = 1'b1;
    else if (x_gt) r[EAST]  = 1'b1;
    else if (x_lt) r[WEST]  = 1'b1;
    else           r[LOCAL] = 1'b1;
`else
    if (x_gt)      r[EAST]  = 1'b1;
    else if (x_lt) r[WEST]  = 1'b1;
    else if (y_lt) r[NORTH] = 1'b1;
    else if (y_gt) r[SOUTH] = 1'b1;
    else           r[LOCAL] = 1'b1;
`endif
    return r;
  endfunction

endpackage

// File: rtl/router_input_unit_if.sv
// Flit/handshake bundle between the input unit, its upstream link and the
// output arbiters. "slave" is the input unit's view, "master" the
// environment's (upstream router plus arbiter/crossbar side).
interface router_input_unit_if
  import router_pkg::*;
#(
  parameter int FLIT_SIZE = 34
);
  logic [FLIT_SIZE-1:0] data_in;
  logic                 data_void_in;
  logic                 stop_out;
  route_t               request;
  logic                 grant;
  logic                 out_stop;
  logic [FLIT_SIZE-1:0] data_out;
  logic                 forwarding_head;
  logic                 forwarding_tail;

  modport slave (
    input  data_in, data_void_in, grant, out_stop,
    output stop_out, request, data_out, forwarding_head, forwarding_tail
  );

  modport master (
    output data_in, data_void_in, grant, out_stop,
    input  stop_out, request, data_out, forwarding_head, forwarding_tail
  );
endinterface

// File: rtl/router_fifo.sv
// Show-ahead FIFO with power-of-two depth. A push while full is dropped
// unless a pop happens in the same cycle, in which case both take effect.
// The output reads zero while empty.
module router_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; holds data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/router_input_unit.sv
// NoC router input port: buffers flits, routes each packet from its head flit
// (dimension-ordered), and holds a one-hot request toward the chosen output
// until the tail flit is forwarded.
// Build option: ROUTER_INPUT_UNIT_YX_ROUTING_EN selects YX order (default XY).
module router_input_unit
  import router_pkg::*;
#(
  parameter int FLIT_SIZE = 34,
  parameter int DEPTH     = 4,
  parameter int COORD_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] position_x,
  input  logic [COORD_W-1:0] position_y,
  router_input_unit_if.slave bus
);
  localparam int CNT_W      = $clog2(DEPTH) + 1;
  localparam int HEAD_BIT   = FLIT_SIZE - 1 - HEAD_OFS;
  localparam int TAIL_BIT   = FLIT_SIZE - 1 - TAIL_OFS;
  localparam int DEST_Y_MSB = FLIT_SIZE - 1 - DEST_Y_OFS;
  localparam int DEST_X_MSB = DEST_Y_MSB - COORD_W;

  logic [FLIT_SIZE-1:0] head_flit;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic                 push;
  logic                 pop;
  logic                 fwd_pop;
  logic                 discard;
  logic                 head_bit;
  logic                 tail_bit;
  logic [COORD_W-1:0]   dest_x;
  logic [COORD_W-1:0]   dest_y;
  route_t               route_d;
  route_t               route_q;
  route_t               request;
  iu_state_t            state;

  // stop_out leaves one free slot, so a flit already in flight when upstream
  // sees stop is still accepted; only a push into a truly full FIFO is lost.
  assign push = ~bus.data_void_in;

  router_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FLIT_SIZE)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.data_in),
    .dout  (head_flit),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_bit = head_flit[HEAD_BIT];
  assign tail_bit = head_flit[TAIL_BIT];
  assign dest_y   = head_flit[DEST_Y_MSB -: COORD_W];
  assign dest_x   = head_flit[DEST_X_MSB -: COORD_W];

  assign route_d = route_select(dest_x > position_x, dest_x < position_x,
                                dest_y > position_y, dest_y < position_y);

  // A stray body flit at the head while idle is dropped without being
  // requested; it never produces forwarding pulses toward the arbiter.
  assign discard = (state == IU_IDLE) & ~fifo_empty & ~head_bit;
  assign fwd_pop = ~fifo_empty & ~discard & bus.grant & ~bus.out_stop;
  assign pop     = fwd_pop | discard;

  assign bus.stop_out        = fifo_full | (fifo_count == CNT_W'(DEPTH - 1));
  assign bus.data_out        = head_flit;
  assign bus.forwarding_head = fwd_pop & head_bit;
  assign bus.forwarding_tail = fwd_pop & tail_bit;
  assign bus.request         = request;

  // Request: freshly decoded route while idle, latched route inside a packet.
  always_comb begin
    request = '0;
    if (!fifo_empty) begin
      if (state == IU_PACKET) request = route_q;
      else if (head_bit)      request = route_d;
    end
  end

  // Packet FSM: a forwarded head without tail opens a packet, its tail closes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IU_IDLE;
      route_q <= '0;
    end else if (fwd_pop) begin
      case (state)
        IU_IDLE: begin
          if (!tail_bit) begin
            route_q <= route_d;
            state   <= IU_PACKET;
          end
        end
        IU_PACKET: begin
          if (tail_bit) state <= IU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_input_unit.sv
// Self-checking bench for router_input_unit: directed scenarios followed by a
// randomized run against a queue-based behavioural model.
module tb_router_input_unit;
  localparam int FS    = 34;
  localparam int DEPTH = 4;
  localparam logic [4:0] R_N = 5'b00001;
  localparam logic [4:0] R_S = 5'b00010;
  localparam logic [4:0] R_W = 5'b00100;
  localparam logic [4:0] R_E = 5'b01000;
  localparam logic [4:0] R_L = 5'b10000;
`ifdef ROUTER_INPUT_UNIT_YX_ROUTING_EN
  localparam logic [4:0] R_DEST02 = R_S;
`else
  localparam logic [4:0] R_DEST02 = R_W;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] pos_x;
  logic [2:0] pos_y;
  int         checks;
  int         errors;

  router_input_unit_if #(.FLIT_SIZE(FS)) bus ();

  router_input_unit #(.FLIT_SIZE(FS), .DEPTH(DEPTH), .COORD_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .position_x (pos_x),
    .position_y (pos_y),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FS-1:0] mk(input logic h, input logic t, input int dx, input int dy);
    logic [25:0] pl;
    pl = 26'($urandom);
    return {h, t, 3'(dy), 3'(dx), pl};
  endfunction

  function automatic logic [4:0] model_route(input int px, input int py, input int dx, input int dy);
`ifdef ROUTER_INPUT_UNIT_YX_ROUTING_EN
    if (dy < py) return R_N;
    if (dy > py) return R_S;
    if (dx > px) return R_E;
    if (dx < px) return R_W;
`else
    if (dx > px) return R_E;
    if (dx < px) return R_W;
    if (dy < py) return R_N;
    if (dy > py) return R_S;
`endif
    return R_L;
  endfunction

  task automatic test_reset();
    rst = 1'b1; bus.data_void_in = 1'b1; bus.grant = 1'b0; bus.out_stop = 1'b0;
    bus.data_in = '0; pos_x = 3'd1; pos_y = 3'd1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.request !== 5'b0) begin errors++; $display("FAIL reset_request: got %b expected %b", bus.request, 5'b0); end
    checks++; if (bus.stop_out !== 1'b0) begin errors++; $display("FAIL reset_stop: got %b expected 0", bus.stop_out); end
    checks++; if (bus.forwarding_head !== 1'b0) begin errors++; $display("FAIL reset_fh: got %b expected 0", bus.forwarding_head); end
    checks++; if (bus.forwarding_tail !== 1'b0) begin errors++; $display("FAIL reset_ft: got %b expected 0", bus.forwarding_tail); end
    checks++; if (bus.data_out !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.data_out); end
    rst = 1'b0;
  endtask

  task automatic test_single_flit();
    logic [FS-1:0] f;
    f = mk(1'b1, 1'b1, 3, 1);
    @(negedge clk); bus.data_in = f; bus.data_void_in = 1'b0; bus.grant = 1'b0;
    #1;
    checks++; if (bus.request !== 5'b0) begin errors++; $display("FAIL single_req_before: got %b expected 0", bus.request); end
    @(negedge clk); bus.data_void_in = 1'b1;
    #1;
    checks++; if (bus.request !== R_E) begin errors++; $display("FAIL single_req: got %b expected %b", bus.request, R_E); end
    checks++; if (bus.data_out !== f) begin errors++; $display("FAIL single_data: got %h expected %h", bus.data_out, f); end
    checks++; if (bus.forwarding_head !== 1'b0) begin errors++; $display("FAIL single_fh_nogrant: got %b expected 0", bus.forwarding_head); end
    @(negedge clk); bus.grant = 1'b1;
    #1;
    checks++; if (bus.forwarding_head !== 1'b1) begin errors++; $display("FAIL single_fh: got %b expected 1", bus.forwarding_head); end
    checks++; if (bus.forwarding_tail !== 1'b1) begin errors++; $display("FAIL single_ft: got %b expected 1", bus.forwarding_tail); end
    @(negedge clk); bus.grant = 1'b0;
    #1;
    checks++; if (bus.request !== 5'b0) begin errors++; $display("FAIL single_req_after: got %b expected 0", bus.request); end
    checks++; if (bus.forwarding_tail !== 1'b0) begin errors++; $display("FAIL single_ft_after: got %b expected 0", bus.forwarding_tail); end
  endtask

  task automatic test_packet_stall();
    logic [FS-1:0] h, b1, b2, t;
    h = mk(1'b1, 1'b0, 1, 0); b1 = mk(1'b0, 1'b0, 3, 7); b2 = mk(1'b0, 1'b0, 7, 7); t = mk(1'b0, 1'b1, 0, 0);
    @(negedge clk); bus.data_in = h; bus.data_void_in = 1'b0; bus.grant = 1'b0; bus.out_stop = 1'b0;
    @(negedge clk); bus.data_in = b1; bus.grant = 1'b1;
    #1;
    checks++; if (bus.request !== R_N) begin errors++; $display("FAIL pkt_req_head: got %b expected %b", bus.request, R_N); end
    checks++; if (bus.forwarding_head !== 1'b1) begin errors++; $display("FAIL pkt_fh: got %b expected 1", bus.forwarding_head); end
    checks++; if (bus.forwarding_tail !== 1'b0) begin errors++; $display("FAIL pkt_ft_head: got %b expected 0", bus.forwarding_tail); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); bus.data_void_in = 1'b1; bus.out_stop = 1'b1;
      #1;
      checks++; if (bus.request !== R_N) begin errors++; $display("FAIL pkt_req_stall%0d: got %b expected %b", i, bus.request, R_N); end
      checks++; if (bus.forwarding_head !== 1'b0 || bus.forwarding_tail !== 1'b0) begin errors++; $display("FAIL pkt_fwd_stall%0d: got %b%b expected 00", i, bus.forwarding_head, bus.forwarding_tail); end
    end
    @(negedge clk); bus.out_stop = 1'b0;
    #1;
    checks++; if (bus.data_out !== b1) begin errors++; $display("FAIL pkt_data_b1: got %h expected %h", bus.data_out, b1); end
    checks++; if (bus.forwarding_tail !== 1'b0) begin errors++; $display("FAIL pkt_ft_b1: got %b expected 0", bus.forwarding_tail); end
    @(negedge clk); bus.data_in = b2; bus.data_void_in = 1'b0; bus.grant = 1'b0;
    #1;
    checks++; if (bus.request !== 5'b0) begin errors++; $display("FAIL pkt_req_empty: got %b expected 0", bus.request); end
    @(negedge clk); bus.data_in = t; bus.grant = 1'b1;
    #1;
    checks++; if (bus.request !== R_N) begin errors++; $display("FAIL pkt_req_b2: got %b expected %b", bus.request, R_N); end
    checks++; if (bus.forwarding_tail !== 1'b0) begin errors++; $display("FAIL pkt_ft_b2: got %b expected 0", bus.forwarding_tail); end
    @(negedge clk); bus.data_void_in = 1'b1;
    #1;
    checks++; if (bus.request !== R_N) begin errors++; $display("FAIL pkt_req_tail: got %b expected %b", bus.request, R_N); end
    checks++; if (bus.forwarding_tail !== 1'b1) begin errors++; $display("FAIL pkt_ft_tail: got %b expected 1", bus.forwarding_tail); end
    checks++; if (bus.forwarding_head !== 1'b0) begin errors++; $display("FAIL pkt_fh_tail: got %b expected 0", bus.forwarding_head); end
    @(negedge clk); bus.grant = 1'b0;
    #1;
    checks++; if (bus.request !== 5'b0) begin errors++; $display("FAIL pkt_req_done: got %b expected 0", bus.request); end
  endtask

  task automatic test_local_west();
    @(negedge clk); bus.data_in = mk(1'b1, 1'b1, 1, 1); bus.data_void_in = 1'b0; bus.grant = 1'b0;
    @(negedge clk); bus.data_void_in = 1'b1; bus.grant = 1'b1;
    #1;
    checks++; if (bus.request !== R_L) begin errors++; $display("FAIL local_req: got %b expected %b", bus.request, R_L); end
    @(negedge clk); bus.data_in = mk(1'b1, 1'b1, 0, 2); bus.data_void_in = 1'b0; bus.grant = 1'b0;
    @(negedge clk); bus.data_void_in = 1'b1; bus.grant = 1'b1;
    #1;
    checks++; if (bus.request !== R_DEST02) begin errors++; $display("FAIL dest02_req: got %b expected %b", bus.request, R_DEST02); end
    @(negedge clk); bus.grant = 1'b0;
  endtask

  task automatic test_fill();
    logic [FS-1:0] f [5];
    logic [FS-1:0] x;
    logic          exp_stop;
    for (int i = 0; i < 4; i++) f[i] = mk(1'b1, 1'b1, i, i);
    f[4] = mk(1'b1, 1'b1, 5, 5);
    x = mk(1'b1, 1'b1, 6, 6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.data_in = f[i]; bus.data_void_in = 1'b0; bus.grant = 1'b0;
      #1;
      exp_stop = (i >= 3);
      checks++; if (bus.stop_out !== exp_stop) begin errors++; $display("FAIL fill_stop%0d: got %b expected %b", i, bus.stop_out, exp_stop); end
    end
    @(negedge clk); bus.data_in = x;
    #1;
    checks++; if (bus.stop_out !== 1'b1) begin errors++; $display("FAIL fill_stop_full: got %b expected 1", bus.stop_out); end
    @(negedge clk); bus.data_in = f[4]; bus.grant = 1'b1;
    #1;
    checks++; if (bus.data_out !== f[0]) begin errors++; $display("FAIL fill_data0: got %h expected %h", bus.data_out, f[0]); end
    for (int i = 1; i < 5; i++) begin
      @(negedge clk); bus.data_void_in = 1'b1;
      #1;
      exp_stop = (i <= 2);
      checks++; if (bus.data_out !== f[i]) begin errors++; $display("FAIL fill_data%0d: got %h expected %h", i, bus.data_out, f[i]); end
      checks++; if (bus.stop_out !== exp_stop) begin errors++; $display("FAIL fill_drain_stop%0d: got %b expected %b", i, bus.stop_out, exp_stop); end
    end
    @(negedge clk); bus.grant = 1'b0;
    #1;
    checks++; if (bus.data_out !== '0) begin errors++; $display("FAIL fill_empty: got %h expected 0", bus.data_out); end
  endtask

  task automatic test_reset_mid_packet();
    @(negedge clk); bus.data_in = mk(1'b1, 1'b0, 3, 1); bus.data_void_in = 1'b0; bus.grant = 1'b0;
    @(negedge clk); bus.data_in = mk(1'b0, 1'b0, 0, 0); bus.grant = 1'b1;
    #1;
    checks++; if (bus.request !== R_E) begin errors++; $display("FAIL rstpkt_req: got %b expected %b", bus.request, R_E); end
    @(negedge clk); bus.data_void_in = 1'b1; bus.grant = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if (bus.request !== 5'b0) begin errors++; $display("FAIL rstpkt_req_after: got %b expected 0", bus.request); end
    checks++; if (bus.data_out !== '0) begin errors++; $display("FAIL rstpkt_empty: got %h expected 0", bus.data_out); end
    @(negedge clk); bus.data_in = mk(1'b1, 1'b1, 1, 2); bus.data_void_in = 1'b0;
    @(negedge clk); bus.data_void_in = 1'b1; bus.grant = 1'b1;
    #1;
    checks++; if (bus.request !== R_S) begin errors++; $display("FAIL rstpkt_new_req: got %b expected %b", bus.request, R_S); end
    checks++; if (bus.forwarding_head !== 1'b1 || bus.forwarding_tail !== 1'b1) begin errors++; $display("FAIL rstpkt_new_fwd: got %b%b expected 11", bus.forwarding_head, bus.forwarding_tail); end
    @(negedge clk); bus.grant = 1'b0;
  endtask

  task automatic test_non_head();
    logic [FS-1:0] s, h;
    s = mk(1'b0, 1'b1, 3, 1); h = mk(1'b1, 1'b1, 1, 0);
    @(negedge clk); bus.data_in = s; bus.data_void_in = 1'b0; bus.grant = 1'b0;
    @(negedge clk); bus.data_in = h;
    #1;
    checks++; if (bus.request !== 5'b0) begin errors++; $display("FAIL stray_req: got %b expected 0", bus.request); end
    checks++; if (bus.forwarding_tail !== 1'b0) begin errors++; $display("FAIL stray_ft: got %b expected 0", bus.forwarding_tail); end
    @(negedge clk); bus.data_void_in = 1'b1; bus.grant = 1'b1;
    #1;
    checks++; if (bus.data_out !== h) begin errors++; $display("FAIL stray_next_data: got %h expected %h", bus.data_out, h); end
    checks++; if (bus.request !== R_N) begin errors++; $display("FAIL stray_next_req: got %b expected %b", bus.request, R_N); end
    @(negedge clk); bus.grant = 1'b0;
    #1;
    checks++; if (bus.request !== 5'b0) begin errors++; $display("FAIL stray_done: got %b expected 0", bus.request); end
  endtask

  task automatic test_random();
    logic [FS-1:0] q [$];
    logic [FS-1:0] exp_data, flit, popped_f;
    logic [4:0]    exp_req, pkt_route;
    logic          in_pkt, empty, head, tail, discard, g, os, send, fwd, popped, prev_stop, exp_stop;
    int            tx_len, tx_idx, tx_dx, tx_dy;
    rst = 1'b1; bus.data_void_in = 1'b1; bus.grant = 1'b0; bus.out_stop = 1'b0;
    pos_x = 3'($urandom_range(0, 7)); pos_y = 3'($urandom_range(0, 7));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_pkt = 1'b0; pkt_route = '0; prev_stop = 1'b0; tx_len = 0; tx_idx = 0; tx_dx = 0; tx_dy = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      empty    = (q.size() == 0);
      exp_data = empty ? '0 : q[0];
      exp_stop = (q.size() >= DEPTH - 1);
      head     = !empty && exp_data[FS-1];
      tail     = !empty && exp_data[FS-2];
      if (empty)       exp_req = '0;
      else if (in_pkt) exp_req = pkt_route;
      else if (head)   exp_req = model_route(int'(pos_x), int'(pos_y), int'(exp_data[28:26]), int'(exp_data[31:29]));
      else             exp_req = '0;
      discard = !empty && !in_pkt && !head;
      g    = (exp_req != 5'b0) && ($urandom_range(0, 3) != 0);
      os   = ($urandom_range(0, 4) == 0);
      send = ($urandom_range(0, 3) != 0) && (!prev_stop || $urandom_range(0, 7) == 0);
      flit = '0;
      if (send) begin
        if (tx_idx >= tx_len && $urandom_range(0, 11) == 0) begin
          flit = mk(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7));
        end else begin
          if (tx_idx >= tx_len) begin
            tx_len = $urandom_range(1, 4); tx_idx = 0;
            tx_dx = $urandom_range(0, 7); tx_dy = $urandom_range(0, 7);
          end
          if (tx_idx == 0) flit = mk(1'b1, tx_len == 1, tx_dx, tx_dy);
          else             flit = mk(1'b0, tx_idx == tx_len - 1, $urandom_range(0, 7), $urandom_range(0, 7));
          tx_idx++;
        end
      end
      bus.data_in = flit; bus.data_void_in = !send; bus.grant = g; bus.out_stop = os;
      #1;
      fwd = !empty && g && !os;
      checks++; if (bus.request !== exp_req) begin errors++; $display("FAIL rand_req c%0d: got %b expected %b", cyc, bus.request, exp_req); end
      checks++; if (bus.data_out !== exp_data) begin errors++; $display("FAIL rand_data c%0d: got %h expected %h", cyc, bus.data_out, exp_data); end
      checks++; if (bus.stop_out !== exp_stop) begin errors++; $display("FAIL rand_stop c%0d: got %b expected %b", cyc, bus.stop_out, exp_stop); end
      checks++; if (bus.forwarding_head !== (fwd && head)) begin errors++; $display("FAIL rand_fh c%0d: got %b expected %b", cyc, bus.forwarding_head, fwd && head); end
      checks++; if (bus.forwarding_tail !== (fwd && tail)) begin errors++; $display("FAIL rand_ft c%0d: got %b expected %b", cyc, bus.forwarding_tail, fwd && tail); end
      popped = fwd || discard;
      if (send && (q.size() < DEPTH || popped)) q.push_back(flit);
      if (popped) begin
        popped_f = q.pop_front();
        if (fwd) begin
          if (!in_pkt && popped_f[FS-1] && !popped_f[FS-2]) begin
            in_pkt = 1'b1; pkt_route = exp_req;
          end else if (in_pkt && popped_f[FS-2]) begin
            in_pkt = 1'b0;
          end
        end
      end
      prev_stop = exp_stop;
    end
    @(negedge clk); bus.data_void_in = 1'b1; bus.grant = 1'b0; bus.out_stop = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_flit();
    test_packet_stall();
    test_local_west();
    test_fill();
    test_reset_mid_packet();
    test_non_head();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
